// File: rtl/car_track_pkg.sv
// Shared types for the multi-gate hourly car tracker: FSM state encoding,
// the default-width log record and a small population-count helper.
package car_track_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } track_state_t;

  // Default count width; modules carry their own CNT_W and build a record
  // type of the same shape from it.
  localparam int REC_CNT_W = 16;

  // Wide enough to hold the number of edges from up to 8 gates in one cycle.
  localparam int EDGE_W = 4;

  typedef struct packed {
    logic [REC_CNT_W-1:0] hour_cnt;
    logic [REC_CNT_W-1:0] total;
  } track_rec_t;

  // Number of set bits in an 8-bit vector (gates are zero-extended to 8).
  function automatic logic [EDGE_W-1:0] popcount8(input logic [7:0] v);
    logic [EDGE_W-1:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + EDGE_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/car_track_multi_ram.sv
// track_ram: simple dual-port log RAM. One write port, one synchronous read
// port with a registered output and a matching valid flag. A read and a write
// to the same address in one cycle returns the previous contents. The array
// itself is never reset; only the read output register is.
module track_ram #(
  parameter int DW    = 32,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid
);

  logic [DW-1:0] mem [DEPTH];

  // Write port: storage array, intentionally without reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: registered data plus a one-cycle valid pulse per read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= mem[rd_addr];
      end
    end
  end

endmodule

// File: rtl/car_track_multi.sv
// car_track_multi: counts rising edges on NUM_GATES entry sensors, logs
// {hour_cnt, total} per hour into track_ram and plays the log back newest
// hour first, one record per second strobe, once the work day has ended.
// Optional peak tracking is compiled in when CAR_TRACK_PEAK_EN is defined;
// otherwise peak_cnt/peak_hour are tied to zero.
//
// Handshake: rd_valid is a one-cycle pulse with no back-pressure; rd_addr,
// rd_hour_cnt and rd_total are meaningful only in the cycle rd_valid is high.
import car_track_pkg::*;

module car_track_multi #(
  parameter int NUM_GATES = 2,
  parameter int HOURS     = 8,
  parameter int CNT_W     = 16,
  parameter int ADDR_W    = $clog2(HOURS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_GATES-1:0] car_enter,
  input  logic [3:0]           work_hour,
  input  logic                 expired_one_hour,
  input  logic                 expired_one_second,
  input  logic                 work_day_expired,
  output logic [ADDR_W-1:0]    rd_addr,
  output logic [CNT_W-1:0]     rd_hour_cnt,
  output logic [CNT_W-1:0]     rd_total,
  output logic                 rd_valid,
  output logic                 playing,
  output logic                 hour_ovf,
  output logic [CNT_W-1:0]     peak_cnt,
  output logic [ADDR_W-1:0]    peak_hour,
  output track_state_t         dbg_state
);

  typedef struct packed {
    logic [CNT_W-1:0] hour_cnt;
    logic [CNT_W-1:0] total;
  } rec_t;

  // Add a per-cycle edge count, clamping at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [EDGE_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  logic [NUM_GATES-1:0] pipe0, pipe1;
  logic [EDGE_W-1:0]    edges;
  logic [CNT_W-1:0]     hour_cnt, total;
  logic                 wr_en_q;
  logic [ADDR_W-1:0]    wr_addr_q;
  rec_t                 wr_data_q, rd_rec;
  track_state_t         state, state_nxt;
  logic [ADDR_W-1:0]    rd_addr_q, rd_addr_nxt;
  logic                 rd_req_q, rd_req_nxt;
  logic                 day_clear;
  logic                 hour_strobe, hour_in_range;

  assign edges         = popcount8(8'(pipe0 & ~pipe1));
  assign hour_strobe   = (state == IDLE) && expired_one_hour;
  assign hour_in_range = 32'(work_hour) < 32'(HOURS);

  // Two-flop history per gate; a 0->1 step between the flops is one car.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe0 <= '0;
      pipe1 <= '0;
    end else begin
      pipe0 <= car_enter;
      pipe1 <= pipe0;
    end
  end

  // Hourly/day counters and the registered write request. The snapshot is
  // taken before this cycle's edges are added, so those edges start the new
  // hour instead.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hour_cnt  <= '0;
      total     <= '0;
      hour_ovf  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (day_clear) begin
        hour_cnt <= '0;
        total    <= '0;
        hour_ovf <= 1'b0;
      end else begin
        total <= sat_add(total, edges);
        if (hour_strobe) begin
          hour_cnt <= CNT_W'(edges);
          if (hour_in_range) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= work_hour[ADDR_W-1:0];
            wr_data_q <= '{hour_cnt: hour_cnt, total: total};
          end else begin
            hour_ovf <= 1'b1;
          end
        end else begin
          hour_cnt <= sat_add(hour_cnt, edges);
        end
      end
    end
  end

  // FSM state, playback address and read-issue register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rd_addr_q <= '0;
      rd_req_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      rd_addr_q <= rd_addr_nxt;
      rd_req_q  <= rd_req_nxt;
    end
  end

  // Next-state logic: start playback at the top address, step down one
  // record per second, and park at address 0 after the last read.
  always_comb begin
    state_nxt   = state;
    rd_addr_nxt = rd_addr_q;
    rd_req_nxt  = 1'b0;
    day_clear   = 1'b0;
    case (state)
      IDLE: begin
        if (work_day_expired) begin
          state_nxt   = PLAY;
          rd_addr_nxt = ADDR_W'(HOURS - 1);
          rd_req_nxt  = 1'b1;
        end
      end
      PLAY: begin
        if (!work_day_expired) begin
          state_nxt = IDLE;
          day_clear = 1'b1;
        end else if (expired_one_second) begin
          rd_addr_nxt = rd_addr_q - ADDR_W'(1);
          rd_req_nxt  = 1'b1;
          if (rd_addr_q == ADDR_W'(1)) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        rd_addr_nxt = '0;
        if (!work_day_expired) begin
          state_nxt = IDLE;
          day_clear = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  track_ram #(
    .DW    (2 * CNT_W),
    .DEPTH (HOURS),
    .AW    (ADDR_W)
  ) u_ram (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en_q),
    .wr_addr  (wr_addr_q),
    .wr_data  (wr_data_q),
    .rd_en    (rd_req_q),
    .rd_addr  (rd_addr_q),
    .rd_data  (rd_rec),
    .rd_valid (rd_valid)
  );

  assign rd_addr     = rd_addr_q;
  assign rd_hour_cnt = rd_rec.hour_cnt;
  assign rd_total    = rd_rec.total;
  assign playing     = (state == PLAY);
  assign dbg_state   = state;

`ifdef CAR_TRACK_PEAK_EN
  logic [CNT_W-1:0]  peak_cnt_q;
  logic [ADDR_W-1:0] peak_hour_q;

  // Track the busiest logged hour; strict compare keeps the earlier hour on ties.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      peak_cnt_q  <= '0;
      peak_hour_q <= '0;
    end else if (day_clear) begin
      peak_cnt_q  <= '0;
      peak_hour_q <= '0;
    end else if (wr_en_q && (wr_data_q.hour_cnt > peak_cnt_q)) begin
      peak_cnt_q  <= wr_data_q.hour_cnt;
      peak_hour_q <= wr_addr_q;
    end
  end

  assign peak_cnt  = peak_cnt_q;
  assign peak_hour = peak_hour_q;
`else
  assign peak_cnt  = '0;
  assign peak_hour = '0;
`endif

endmodule

// File: tb/tb_car_track_multi.sv
// Directed bench for car_track_multi: DUT A uses default parameters, DUT B
// uses CNT_W = 4 to exercise saturation and the out-of-range hour strobe.
module tb_car_track_multi;
  import car_track_pkg::*;

  localparam int NG  = 2;
  localparam int HRS = 8;
  localparam int CW  = 16;
  localparam int CWB = 4;
  localparam int AW  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // ---------------- DUT A ----------------
  logic [NG-1:0] a_car;
  logic [3:0]    a_hour;
  logic          a_eoh, a_eos, a_wde;
  logic [AW-1:0] a_rd_addr, a_peak_hour;
  logic [CW-1:0] a_rd_hour_cnt, a_rd_total, a_peak_cnt;
  logic          a_rd_valid, a_playing, a_hour_ovf;
  track_state_t  a_state;

  car_track_multi #(.NUM_GATES(NG), .HOURS(HRS), .CNT_W(CW)) u_a (
    .clk(clk), .reset_n(reset_n), .car_enter(a_car), .work_hour(a_hour),
    .expired_one_hour(a_eoh), .expired_one_second(a_eos), .work_day_expired(a_wde),
    .rd_addr(a_rd_addr), .rd_hour_cnt(a_rd_hour_cnt), .rd_total(a_rd_total),
    .rd_valid(a_rd_valid), .playing(a_playing), .hour_ovf(a_hour_ovf),
    .peak_cnt(a_peak_cnt), .peak_hour(a_peak_hour), .dbg_state(a_state)
  );

  // ---------------- DUT B ----------------
  logic [NG-1:0]  b_car;
  logic [3:0]     b_hour;
  logic           b_eoh, b_eos, b_wde;
  logic [AW-1:0]  b_rd_addr, b_peak_hour;
  logic [CWB-1:0] b_rd_hour_cnt, b_rd_total, b_peak_cnt;
  logic           b_rd_valid, b_playing, b_hour_ovf;
  track_state_t   b_state;

  car_track_multi #(.NUM_GATES(NG), .HOURS(HRS), .CNT_W(CWB)) u_b (
    .clk(clk), .reset_n(reset_n), .car_enter(b_car), .work_hour(b_hour),
    .expired_one_hour(b_eoh), .expired_one_second(b_eos), .work_day_expired(b_wde),
    .rd_addr(b_rd_addr), .rd_hour_cnt(b_rd_hour_cnt), .rd_total(b_rd_total),
    .rd_valid(b_rd_valid), .playing(b_playing), .hour_ovf(b_hour_ovf),
    .peak_cnt(b_peak_cnt), .peak_hour(b_peak_hour), .dbg_state(b_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [AW-1:0] exp_q[$];
  logic [CW-1:0] exp_pk;
  logic [AW-1:0] exp_ph;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_a(input logic [NG-1:0] m);
    a_car = m; tick();
    a_car = '0; tick();
  endtask

  task automatic pulse_b(input logic [NG-1:0] m);
    b_car = m; tick();
    b_car = '0; tick();
  endtask

  task automatic strobe_a(input logic [3:0] h);
    a_hour = h; a_eoh = 1'b1; tick();
    a_eoh = 1'b0; tick();
  endtask

  task automatic strobe_b(input logic [3:0] h);
    b_hour = h; b_eoh = 1'b1; tick();
    b_eoh = 1'b0; tick();
  endtask

  task automatic second_a();
    a_eos = 1'b1; tick();
    a_eos = 1'b0; tick();
  endtask

  task automatic second_b();
    b_eos = 1'b1; tick();
    b_eos = 1'b0; tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    a_car = '0; a_hour = '0; a_eoh = 0; a_eos = 0; a_wde = 0;
    b_car = '0; b_hour = '0; b_eoh = 0; b_eos = 0; b_wde = 0;
    tick(); tick();
    checks++; if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %0b expected 0", a_rd_valid); end
    checks++; if (a_playing !== 1'b0) begin errors++; $display("FAIL reset_playing: got %0b expected 0", a_playing); end
    checks++; if (a_rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr: got %0d expected 0", a_rd_addr); end
    checks++; if (a_rd_hour_cnt !== '0 || a_rd_total !== '0) begin errors++; $display("FAIL reset_rd_data: got %0d/%0d expected 0/0", a_rd_hour_cnt, a_rd_total); end
    checks++; if (a_hour_ovf !== 1'b0 || a_peak_cnt !== '0 || a_peak_hour !== '0) begin errors++; $display("FAIL reset_flags: got ovf %0b peak %0d@%0d expected 0", a_hour_ovf, a_peak_cnt, a_peak_hour); end
    checks++; if (a_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", a_state, IDLE); end
    checks++; if (u_a.total !== '0 || u_a.hour_cnt !== '0) begin errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", u_a.hour_cnt, u_a.total); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_edges();
    pulse_a(2'b01);
    checks++; if (u_a.total !== 16'd1) begin errors++; $display("FAIL edge_gate0: got total %0d expected 1", u_a.total); end
    a_car = 2'b11; tick();
    checks++; if (u_a.total !== 16'd1) begin errors++; $display("FAIL edge_latency: got total %0d expected 1", u_a.total); end
    a_car = 2'b00; tick();
    checks++; if (u_a.total !== 16'd3) begin errors++; $display("FAIL edge_two_gates: got total %0d expected 3", u_a.total); end
    // a level held for several cycles is still a single car
    a_car = 2'b01; tick(); tick(); tick();
    a_car = 2'b00; tick();
    checks++; if (u_a.total !== 16'd4 || u_a.hour_cnt !== 16'd4) begin errors++; $display("FAIL edge_held_level: got %0d/%0d expected 4/4", u_a.hour_cnt, u_a.total); end
  endtask

  task automatic test_hour_log();
    strobe_a(4'd2);
    checks++; if (u_a.hour_cnt !== 16'd0 || u_a.total !== 16'd4) begin errors++; $display("FAIL hour2_restart: got %0d/%0d expected 0/4", u_a.hour_cnt, u_a.total); end
    for (int i = 0; i < 3; i++) pulse_a(2'b10);
    strobe_a(4'd3);
    checks++; if (u_a.hour_cnt !== 16'd0 || u_a.total !== 16'd7) begin errors++; $display("FAIL hour3_restart: got %0d/%0d expected 0/7", u_a.hour_cnt, u_a.total); end
  endtask

  task automatic test_coincident();
    pulse_a(2'b01);
    pulse_a(2'b10);
    a_car = 2'b01; tick();
    a_car = 2'b00; a_hour = 4'd4; a_eoh = 1'b1; tick();
    a_eoh = 1'b0;
    checks++; if (u_a.hour_cnt !== 16'd1 || u_a.total !== 16'd10) begin errors++; $display("FAIL coincident_edge: got %0d/%0d expected 1/10", u_a.hour_cnt, u_a.total); end
    tick();
`ifdef CAR_TRACK_PEAK_EN
    exp_pk = 16'd4; exp_ph = 3'd2;
`else
    exp_pk = 16'd0; exp_ph = 3'd0;
`endif
    checks++; if (a_peak_cnt !== exp_pk || a_peak_hour !== exp_ph) begin errors++; $display("FAIL day1_peak: got %0d@%0d expected %0d@%0d", a_peak_cnt, a_peak_hour, exp_pk, exp_ph); end
  endtask

  task automatic test_playback();
    logic [AW-1:0] ea;
    exp_q = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    a_wde = 1'b1; tick();
    checks++; if (a_rd_valid !== 1'b0 || a_playing !== 1'b1) begin errors++; $display("FAIL play_entry: got valid %0b playing %0b expected 0/1", a_rd_valid, a_playing); end
    tick();
    for (int n = 0; n < HRS; n++) begin
      if (n > 0) second_a();
      ea = exp_q.pop_front();
      checks++; if (a_rd_valid !== 1'b1 || a_rd_addr !== ea) begin errors++; $display("FAIL play_record: got valid %0b addr %0d expected 1 addr %0d", a_rd_valid, a_rd_addr, ea); end
      if (ea == 3'd4) begin
        checks++; if (a_rd_hour_cnt !== 16'd2 || a_rd_total !== 16'd9) begin errors++; $display("FAIL ram4: got %0d/%0d expected 2/9", a_rd_hour_cnt, a_rd_total); end
      end
      if (ea == 3'd3) begin
        checks++; if (a_rd_hour_cnt !== 16'd3 || a_rd_total !== 16'd7) begin errors++; $display("FAIL ram3: got %0d/%0d expected 3/7", a_rd_hour_cnt, a_rd_total); end
      end
      if (ea == 3'd2) begin
        checks++; if (a_rd_hour_cnt !== 16'd4 || a_rd_total !== 16'd4) begin errors++; $display("FAIL ram2: got %0d/%0d expected 4/4", a_rd_hour_cnt, a_rd_total); end
      end
      if (n == 0) begin
        tick();
        checks++; if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL valid_pulse: got %0b expected 0", a_rd_valid); end
      end
    end
    checks++; if (a_state !== DONE || a_playing !== 1'b0) begin errors++; $display("FAIL play_done: got state %0d playing %0b expected %0d/0", a_state, a_playing, DONE); end
    second_a();
    checks++; if (a_rd_valid !== 1'b0 || a_rd_addr !== '0) begin errors++; $display("FAIL done_hold: got valid %0b addr %0d expected 0/0", a_rd_valid, a_rd_addr); end
    a_wde = 1'b0; tick();
    checks++; if (a_state !== IDLE || u_a.total !== '0 || u_a.hour_cnt !== '0 || a_peak_cnt !== '0) begin errors++; $display("FAIL day_clear: got state %0d cnt %0d/%0d peak %0d expected IDLE 0/0 0", a_state, u_a.hour_cnt, u_a.total, a_peak_cnt); end
  endtask

  task automatic test_peak_and_reset();
    for (int i = 0; i < 5; i++) pulse_a(2'b01);
    strobe_a(4'd1);
    for (int i = 0; i < 5; i++) pulse_a(2'b10);
    strobe_a(4'd2);
    for (int i = 0; i < 2; i++) pulse_a(2'b01);
    strobe_a(4'd3);
`ifdef CAR_TRACK_PEAK_EN
    exp_pk = 16'd5; exp_ph = 3'd1;
`else
    exp_pk = 16'd0; exp_ph = 3'd0;
`endif
    checks++; if (a_peak_cnt !== exp_pk || a_peak_hour !== exp_ph) begin errors++; $display("FAIL peak_tie: got %0d@%0d expected %0d@%0d", a_peak_cnt, a_peak_hour, exp_pk, exp_ph); end
    a_wde = 1'b1; tick(); tick();
    checks++; if (a_rd_valid !== 1'b1 || a_playing !== 1'b1) begin errors++; $display("FAIL prereset_play: got valid %0b playing %0b expected 1/1", a_rd_valid, a_playing); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (a_rd_valid !== 1'b0 || a_playing !== 1'b0 || a_state !== IDLE) begin errors++; $display("FAIL async_reset: got valid %0b playing %0b state %0d expected 0/0/IDLE", a_rd_valid, a_playing, a_state); end
    checks++; if (a_rd_addr !== '0 || a_rd_hour_cnt !== '0 || a_peak_cnt !== '0) begin errors++; $display("FAIL async_reset_outs: got addr %0d cnt %0d peak %0d expected 0", a_rd_addr, a_rd_hour_cnt, a_peak_cnt); end
    a_wde = 1'b0; tick();
    reset_n = 1'b1; tick();
  endtask

  task automatic test_saturate_ovf();
    for (int i = 0; i < 10; i++) pulse_b(2'b11);
    checks++; if (u_b.hour_cnt !== 4'd15 || u_b.total !== 4'd15) begin errors++; $display("FAIL saturate: got %0d/%0d expected 15/15", u_b.hour_cnt, u_b.total); end
    strobe_b(4'd1);
    pulse_b(2'b01);
    pulse_b(2'b01);
    checks++; if (u_b.hour_cnt !== 4'd2) begin errors++; $display("FAIL sat_restart: got %0d expected 2", u_b.hour_cnt); end
    strobe_b(4'd9);
    checks++; if (b_hour_ovf !== 1'b1) begin errors++; $display("FAIL hour_ovf: got %0b expected 1", b_hour_ovf); end
    b_wde = 1'b1; tick(); tick();
    checks++; if (b_rd_valid !== 1'b1 || b_rd_addr !== 3'd7) begin errors++; $display("FAIL b_first: got valid %0b addr %0d expected 1/7", b_rd_valid, b_rd_addr); end
    for (int i = 0; i < 6; i++) second_b();
    checks++; if (b_rd_addr !== 3'd1 || b_rd_hour_cnt !== 4'd15 || b_rd_total !== 4'd15) begin errors++; $display("FAIL ovf_no_write: got addr %0d data %0d/%0d expected 1 15/15", b_rd_addr, b_rd_hour_cnt, b_rd_total); end
    checks++; if (b_hour_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b expected 1", b_hour_ovf); end
    second_b();
    b_wde = 1'b0; tick();
    checks++; if (b_hour_ovf !== 1'b0 || b_state !== IDLE) begin errors++; $display("FAIL ovf_clear: got ovf %0b state %0d expected 0/IDLE", b_hour_ovf, b_state); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_edges();
    test_hour_log();
    test_coincident();
    test_playback();
    test_peak_and_reset();
    test_saturate_ovf();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
